// File: rtl/ram16_stream_ctrl.sv
// ram16_stream_ctrl: LOAD/DUMP sequencer in front of a 16x8 sync-write/async-read RAM.
// Define RAM16_CKSUM_EN to append a mod-256 checksum byte to every DUMP pass.
module ram16_stream_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_load,
  input  logic          start_dump,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_di,
  output logic          ram_wre,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_CKSUM = 3'd4;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [2:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic [DW-1:0] r_out_data;
  logic          r_done;
  logic          w_last;
`ifdef RAM16_CKSUM_EN
  logic [DW-1:0] r_sum;
`endif

  // Write strobe is purely combinational on state, so it falls with the async reset.
  assign w_last    = (r_ptr == LAST);
  assign in_ready  = (r_state == S_LOAD);
  assign ram_wre   = in_ready && in_valid;
  assign ram_ad    = r_ptr;
  assign ram_di    = in_ready ? in_data : '0;
  assign out_valid = (r_state == S_SEND) || (r_state == S_CKSUM);
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_out_data <= '0;
      r_done     <= 1'b0;
`ifdef RAM16_CKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_load) begin
            r_state <= S_LOAD;
            r_ptr   <= '0;
          end else if (start_dump) begin
            r_state <= S_FETCH;
            r_ptr   <= '0;
`ifdef RAM16_CKSUM_EN
            r_sum   <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_ptr <= r_ptr + AW'(1);
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          r_out_data <= ram_dout;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            r_ptr <= r_ptr + AW'(1);
`ifdef RAM16_CKSUM_EN
            r_sum <= r_sum + r_out_data;
`endif
            if (!w_last) begin
              r_state <= S_FETCH;
            end else begin
`ifdef RAM16_CKSUM_EN
              // Final sum folds in the last byte directly so the checksum is registered.
              r_out_data <= r_sum + r_out_data;
              r_state    <= S_CKSUM;
`else
              r_state    <= S_IDLE;
              r_done     <= 1'b1;
`endif
            end
          end
        end
        S_CKSUM: begin
          if (out_ready) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
